led_pwm_capture: RTL and testbench

//  Receive-side counterpart of the badge LED PWM driver: samples the multiplexed

---
 rtl/led_pwm_capture.sv | 122 ++++++++++++
 tb/tb_led_pwm_capture.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/led_pwm_capture.sv
// led_pwm_capture: recovers per-LED PWM duty from sampled ledc/ledrgb lines and streams results
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ledc_in           LED source lines (1 = on)
//   ledrgb_in         one-hot colour sink lines, bit n = phase n
//   cap_valid/ready   result handshake; cap_led, cap_color, cap_duty carry the result
//   frame_done        pulse after the final handshake of a phase-2 stream
//   sync_err          pulse when a window is discarded (short, invalid phase or overrun)
// Define LED_PWM_CAPTURE_SYNC2_EN to add a 2-flop synchroniser ahead of the sample stage.
module led_pwm_capture #(
  parameter int NUM_LEDS   = 11,
  parameter int PWM_BITS   = 8,
  parameter int WINDOW_LEN = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] ledc_in,
  input  logic [2:0]          ledrgb_in,
  output logic                cap_valid,
  input  logic                cap_ready,
  output logic [3:0]          cap_led,
  output logic [1:0]          cap_color,
  output logic [PWM_BITS-1:0] cap_duty,
  output logic                frame_done,
  output logic                sync_err
);
  localparam int LW = $clog2(WINDOW_LEN + 2);
  localparam logic [LW-1:0] WL = LW'(WINDOW_LEN);
  localparam logic [3:0] LAST = 4'(NUM_LEDS - 1);
  typedef enum logic {SYNC_WAIT, COUNT} cap_t;
  typedef enum logic {IDLE, STREAM} str_t;
  logic [NUM_LEDS+2:0] w_in;
`ifdef LED_PWM_CAPTURE_SYNC2_EN
  localparam int DEPTH = 4;
  logic [NUM_LEDS+2:0] r_m1, r_m2;
  always_ff @(posedge clk)
    {r_m2, r_m1} <= rst ? '0 : {r_m1, ledrgb_in, ledc_in};
  assign w_in = r_m2;
`else
  localparam int DEPTH = 2;
  assign w_in = {ledrgb_in, ledc_in};
`endif
  logic [NUM_LEDS-1:0] r_s_ledc;
  logic [2:0]          r_s_rgb, r_prev_rgb;
  logic [DEPTH-1:0]    r_live;
  cap_t                r_cst;
  str_t                r_sst;
  logic [LW-1:0]       r_len;
  logic [PWM_BITS-1:0] r_cnt [NUM_LEDS];
  logic [PWM_BITS-1:0] r_shd [NUM_LEDS];
  logic                w_bnd, w_vph, w_full, w_last, w_take, w_err;
  logic [1:0]          w_oph;
  logic [3:0]          w_nled;
  // r_live masks boundary detection until both s_* and the previous sample hold
  // post-reset data, so the window in progress at reset release is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_s_rgb, r_s_ledc} <= '0;
      r_prev_rgb          <= '0;
      r_live              <= '0;
    end else begin
      {r_s_rgb, r_s_ledc} <= w_in;
      r_prev_rgb          <= r_s_rgb;
      r_live              <= {r_live[DEPTH-2:0], 1'b1};
    end
  end
  assign w_bnd  = r_live[DEPTH-1] && (r_s_rgb != r_prev_rgb);
  assign w_vph  = (r_s_rgb != 3'b000) && ((r_s_rgb & (r_s_rgb - 3'd1)) == 3'b000);
  assign w_oph  = r_prev_rgb[2] ? 2'd2 : {1'b0, r_prev_rgb[1]};
  assign w_full = (r_cst == COUNT) && (r_len == WL);
  assign w_last = cap_valid && cap_ready && (cap_led == LAST);
  // a finishing stream frees the shadow in the same cycle, so no overrun then
  assign w_take = w_bnd && w_full && ((r_sst == IDLE) || w_last);
  assign w_err  = w_bnd && (r_cst == COUNT) && (!w_take || !w_vph);
  assign w_nled = cap_led + 4'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cst    <= SYNC_WAIT;
      r_len    <= '0;
      sync_err <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) r_cnt[i] <= '0;
    end else begin
      sync_err <= w_err;
      if (w_bnd) begin
        // boundary cycle is cycle 1 of the new window
        r_cst <= w_vph ? COUNT : SYNC_WAIT;
        r_len <= LW'(w_vph);
        for (int i = 0; i < NUM_LEDS; i++) r_cnt[i] <= PWM_BITS'(r_s_ledc[i] & w_vph);
      end else if (r_cst == COUNT) begin
        r_len <= r_len + LW'(r_len != WL + 1'b1);
        for (int i = 0; i < NUM_LEDS; i++) r_cnt[i] <= r_cnt[i] + PWM_BITS'(r_s_ledc[i] & ~&r_cnt[i]);
      end
    end
  end
  always_ff @(posedge clk)
    if (w_take) r_shd <= r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sst      <= IDLE;
      cap_valid  <= 1'b0;
      cap_led    <= '0;
      cap_color  <= '0;
      cap_duty   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_last && (cap_color == 2'd2);
      if (w_take) begin
        r_sst     <= STREAM;
        cap_valid <= 1'b1;
        cap_led   <= '0;
        cap_color <= w_oph;
        cap_duty  <= r_cnt[0];
      end else if (w_last) begin
        r_sst     <= IDLE;
        cap_valid <= 1'b0;
      end else if (cap_valid && cap_ready) begin
        cap_led  <= w_nled;
        cap_duty <= r_shd[w_nled];
      end
    end
  end
endmodule

// File: tb/tb_led_pwm_capture.sv
// tb_led_pwm_capture: randomized bench for led_pwm_capture against a segment-level duty model
module tb_led_pwm_capture;
  logic        clk = 0, rst = 1, cap_ready = 0;
  logic [10:0] ledc_in = '0;
  logic [2:0]  ledrgb_in = 3'b100;
  logic        cap_valid, frame_done, sync_err;
  logic [3:0]  cap_led;
  logic [1:0]  cap_color;
  logic [7:0]  cap_duty;
  int n_chk = 0, n_err = 0, cyc = 0, stall_end = 0, exp_err = 0, seen_err = 0;
  logic [13:0] q[$];
  logic [2:0]  p_rgb = 3'b100;
  int          p_len = 0, p_arm = 0;
  int          p_sum [11];
  led_pwm_capture dut (
    .clk(clk), .rst(rst), .ledc_in(ledc_in), .ledrgb_in(ledrgb_in),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_led(cap_led),
    .cap_color(cap_color), .cap_duty(cap_duty), .frame_done(frame_done),
    .sync_err(sync_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit oh(input logic [2:0] x);
    return x == 3'b001 || x == 3'b010 || x == 3'b100;
  endfunction
  // a counted, one-hot segment of exactly 256 cycles yields 11 results unless the
  // previous stream is still outstanding; any other ending of it is a sync error
  task automatic resolve(input logic [2:0] nxt);
    bit full, ovr;
    logic [1:0] col;
    if (p_arm != 0 && oh(p_rgb)) begin
      full = p_len == 256;
      ovr  = q.size() > 0;
      col  = p_rgb == 3'b001 ? 2'd0 : p_rgb == 3'b010 ? 2'd1 : 2'd2;
      if (full && !ovr)
        for (int i = 0; i < 11; i++) q.push_back({4'(i), col, 8'(p_sum[i] > 255 ? 255 : p_sum[i])});
      if (!full || ovr || !oh(nxt)) exp_err++;
    end
  endtask
  task automatic drive(input logic [2:0] rgb, input int n, input int mode);
    logic [10:0] v;
    if (rgb != p_rgb) begin
      resolve(rgb);
      p_rgb = rgb;
      p_len = 0;
      p_arm = 1;
      for (int i = 0; i < 11; i++) p_sum[i] = 0;
    end
    for (int k = 0; k < n; k++) begin
      v = mode == 0 ? 11'($urandom) : mode == 1 ? (k < 128 ? 11'h008 : 11'h000) : 11'($urandom) | 11'h400;
      ledrgb_in = rgb;
      ledc_in   = v;
      for (int i = 0; i < 11; i++) p_sum[i] += int'(v[i]);
      p_len++;
      @(posedge clk); #1;
    end
  endtask
  task automatic reset_dut();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", cap_valid, 0);
    check("rst_led", cap_led, 0);
    check("rst_color", cap_color, 0);
    check("rst_duty", cap_duty, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sync_err", sync_err, 0);
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    p_arm = 0;
  endtask
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    cap_ready = cyc < stall_end ? 1'b0 : ($urandom_range(3) != 0);
  end
  initial begin
    bit fd_exp = 0, hold = 0;
    logic [14:0] hv;
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
        fd_exp = 0;
      end else begin
        if (hold) check("hold", {cap_valid, cap_led, cap_color, cap_duty}, hv);
        if (frame_done || fd_exp) check("frame_done", frame_done, fd_exp);
        if (sync_err) seen_err++;
        hold = 0;
        fd_exp = 0;
        if (cap_valid && cap_ready) begin
          e = q.size() > 0 ? q.pop_front() : 14'h3fff;
          check("result", {cap_led, cap_color, cap_duty}, e);
          fd_exp = cap_led == 4'd10 && cap_color == 2'd2;
        end else if (cap_valid) begin
          hold = 1;
          hv = {cap_valid, cap_led, cap_color, cap_duty};
        end
      end
    end
  end
  initial begin
    reset_dut();
    drive(3'b100, 40, 0);
    drive(3'b001, 256, 1);
    drive(3'b010, 256, 2);
    drive(3'b100, 10, 0);
    check("err_none_yet", seen_err, exp_err);
    drive(3'b100, 246, 0);
    drive(3'b001, 200, 0);
    drive(3'b010, 10, 0);
    check("err_short", seen_err, exp_err);
    drive(3'b010, 246, 0);
    drive(3'b100, 256, 0);
    stall_end = cyc + 300;
    drive(3'b001, 256, 0);
    drive(3'b010, 10, 0);
    check("err_overrun", seen_err, exp_err);
    drive(3'b010, 246, 0);
    drive(3'b100, 256, 0);
    drive(3'b001, 100, 0);
    drive(3'b000, 5, 0);
    drive(3'b001, 256, 0);
    drive(3'b010, 100, 0);
    drive(3'b011, 5, 0);
    drive(3'b010, 256, 0);
    drive(3'b100, 10, 0);
    check("err_invalid", seen_err, exp_err);
    drive(3'b100, 246, 0);
    drive(3'b001, 256, 0);
    drive(3'b010, 256, 2);
    drive(3'b100, 256, 0);
    drive(3'b001, 4, 0);
    reset_dut();
    drive(3'b001, 30, 0);
    drive(3'b010, 256, 0);
    drive(3'b100, 256, 0);
    drive(3'b001, 80, 0);
    check("drain", q.size(), 0);
    check("err_total", seen_err, exp_err);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
